// File: rtl/lcd_pkg.sv
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types, constants and helpers for the LCD write
//                arbiter. Holds the arbiter FSM state encoding, requester
//                indices, word width and small index helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  // Requester indices into req / wr_en / gnt / ack
  localparam int REQ_INIT   = 0;
  localparam int REQ_CHAR   = 1;
  localparam int REQ_FILL   = 2;
  localparam int N_REQ      = 3;

  // Word to the SPI writer: bit8 = DC flag, bits7:0 = payload
  localparam int LCD_WORD_W = 9;

  // Width of a requester index / last-granted pointer
  localparam int PTR_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } lcd_state_e;

  // Next requester index in round-robin order, wrapping from N_REQ-1 to 0.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (oh[k]) idx = PTR_W'(k);
    end
    return idx;
  endfunction

endpackage : lcd_pkg

`default_nettype wire

// File: rtl/lcd_arb_rr_pick.sv
// ============================================================================
//  Module      : lcd_arb_rr_pick
//  Description : Combinational round-robin picker. Among the requests that
//                are also eligible, selects the first one found starting at
//                the index after the last grant and wrapping to 0.
//  Ports       : req_i   - raw request vector
//                elig_i  - eligibility mask (ANDed with req_i)
//                last_i  - index of the previously granted requester
//                pick_o  - one-hot selection (0 when nothing eligible)
//                valid_o - high when pick_o carries a selection
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_arb_rr_pick
  import lcd_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0] last_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] cand;

  assign cand = req_i & elig_i;

  // Walk the N_REQ indices beginning just after last_i; the last index
  // visited is last_i itself, so a lone requester can be re-granted.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = last_i;
    pick_o  = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_next(idx);
      if (!valid_o && cand[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule : lcd_arb_rr_pick

`default_nettype wire

// File: rtl/lcd_write_arbiter.sv
// ============================================================================
//  Module      : lcd_write_arbiter
//  Description : Arbitrates three LCD word sources (init, show_char, fill)
//                onto a single SPI word writer. A requester holds the bus
//                with req, pushes words with one-cycle wr_en strobes and gets
//                one ack per word once the writer reports wr_done.
//                Optional build macro LCD_ARB_TIMEOUT_EN adds a wr_done
//                watchdog of TIMEOUT_CYC cycles with a sticky timeout_err.
//  Ports       : sys_clk_50MHz - clock (rising edge)
//                sys_rst       - synchronous active-high reset
//                req[2:0]      - bus-hold requests (0 init, 1 char, 2 fill)
//                wr_en[2:0]    - per-requester word strobes
//                wr_data0..2   - per-requester 9-bit words
//                init_done     - low: only requester 0 may be granted
//                wr_done       - completion pulse from the SPI writer
//                gnt[2:0]      - registered one-hot grant
//                ack[2:0]      - per-requester word-complete pulse
//                data[8:0]     - word to the SPI writer
//                en_write      - start pulse to the SPI writer
//                busy          - FSM not in IDLE
//                timeout_err   - sticky watchdog flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  sys_clk_50MHz,
  input  logic                  sys_rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      wr_en,
  input  logic [LCD_WORD_W-1:0] wr_data0,
  input  logic [LCD_WORD_W-1:0] wr_data1,
  input  logic [LCD_WORD_W-1:0] wr_data2,
  input  logic                  init_done,
  input  logic                  wr_done,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      ack,
  output logic [LCD_WORD_W-1:0] data,
  output logic                  en_write,
  output logic                  busy,
  output logic                  timeout_err
);

  // The watchdog compares against TIMEOUT_CYC-1, so anything below 2
  // would fire on the first XFER cycle and is rejected at elaboration.
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cyc
    $error("lcd_write_arbiter: TIMEOUT_CYC must be at least 2");
  end

  lcd_state_e            state_q, state_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [LCD_WORD_W-1:0] data_q, data_d;
  logic                  en_write_q, en_write_d;
  // Index of the most recent grant; while in GRANT/XFER it is also the
  // index of the current owner, so no separate owner register is needed.
  logic [PTR_W-1:0]      last_q, last_d;

  logic [N_REQ-1:0]      elig_mask;
  logic [N_REQ-1:0]      pick;
  logic                  pick_vld;
  logic [LCD_WORD_W-1:0] wr_sel;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 13) ? $clog2(TIMEOUT_CYC) : 13;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  // Before the panel is initialised only the init sequencer may own the bus.
  assign elig_mask = init_done ? '1 : (N_REQ'(1) << REQ_INIT);

  lcd_arb_rr_pick u_pick (
    .req_i   (req),
    .elig_i  (elig_mask),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  // Word of the current owner
  always_comb begin
    case (last_q)
      PTR_W'(REQ_INIT): wr_sel = wr_data0;
      PTR_W'(REQ_CHAR): wr_sel = wr_data1;
      PTR_W'(REQ_FILL): wr_sel = wr_data2;
      default:          wr_sel = wr_data2;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    data_d     = data_q;
    en_write_d = 1'b0;
    last_d     = last_q;
`ifdef LCD_ARB_TIMEOUT_EN
    cnt_d         = '0;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          last_d  = onehot_to_idx(pick);
          state_d = GRANT;
        end
      end

      GRANT: begin
        // A strobe wins over a falling req in the same cycle, so the last
        // word of a sequence is never lost.
        if (wr_en[last_q]) begin
          data_d     = wr_sel;
          en_write_d = 1'b1;
          state_d    = XFER;
        end else if (!req[last_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end

      XFER: begin
        // wr_done has priority over a coincident watchdog expiry.
        if (wr_done) begin
          ack_d   = gnt_q;
          state_d = GRANT;
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          ack_d         = gnt_q;
          timeout_err_d = 1'b1;
          state_d       = GRANT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      en_write_q <= 1'b0;
      last_q     <= PTR_W'(N_REQ - 1);  // requester 0 is first after reset
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      en_write_q <= en_write_d;
      last_q     <= last_d;
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign data     = data_q;
  assign en_write = en_write_q;
  assign busy     = (state_q != IDLE);

endmodule : lcd_write_arbiter

`default_nettype wire
